dc_access_ctrl: RTL and testbench

//  Responder side of the dcache read/write arbitration interface. Accepts the one-hot ren/wen

---
 rtl/dc_access_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dc_access_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_access_ctrl.sv
// rtl/dc_access_ctrl.sv - dcache access responder: tag/valid state, access FSM, data array and bus sequencing
//
// Purpose: serves one-hot ren/wen grants against a direct-mapped, write-through,
// no-write-allocate dcache. Tag/valid live here; the line data lives in an external
// SRAM (da_*); read misses and all writes go out on the system bus (bus_*).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ren, rd_addr                    read grant and address (held until ld_ro)
//   wen, wr_addr, wr_data, wr_be    write grant, address, line data, byte enables (held until mem_wr_done)
//   ld_ro, rd_data                  read done pulse and registered read line
//   mem_wr_done                     write done pulse
//   da_en, da_we, da_idx,
//   da_wdata, da_be, da_rdata       data array SRAM port (read data one cycle after the enable cycle)
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_be, bus_ack,
//   bus_rdata                       system bus, request held until the one-cycle ack

module dc_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5,
  parameter int OFF_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ren,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                ld_ro,
  output logic [DATA_W-1:0]   rd_data,
  output logic                mem_wr_done,
  output logic                da_en,
  output logic                da_we,
  output logic [IDX_W-1:0]    da_idx,
  output logic [DATA_W-1:0]   da_wdata,
  output logic [DATA_W/8-1:0] da_be,
  input  logic [DATA_W-1:0]   da_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BE_W   = DATA_W / 8;
  localparam int NLINES = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, RLOOK, FILL, RRESP, WLOOK, WBUS, WRESP} state_t;

  state_t state_q, state_d;

  // RLOOK spans two cycles: the SRAM read is launched in the first, its data arrives in the second.
  logic              phase_q, phase_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_arr [NLINES];
  logic              fill_we;

  logic              ld_ro_d, mem_wr_done_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              da_en_d, da_we_d;
  logic [IDX_W-1:0]  da_idx_d;
  logic [DATA_W-1:0] da_wdata_d;
  logic [BE_W-1:0]   da_be_d;
  logic              bus_req_d, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic [BE_W-1:0]   bus_be_d;

  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              hit;

  // Accesses are whole lines, so the byte offset of an address carries no information.
  logic unused_off;
  assign unused_off = ^{rd_addr[OFF_W-1:0], wr_addr[OFF_W-1:0]};

  assign idx_q = line_q[IDX_W-1:0];
  assign tag_q = line_q[LINE_W-1:IDX_W];
  assign hit   = valid_q[idx_q] && (tag_arr[idx_q] == tag_q);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    line_d        = line_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    fill_we       = 1'b0;
    ld_ro_d       = 1'b0;
    mem_wr_done_d = 1'b0;
    rd_data_d     = rd_data;
    da_en_d       = 1'b0;
    da_we_d       = 1'b0;
    da_idx_d      = da_idx;
    da_wdata_d    = da_wdata;
    da_be_d       = da_be;
    bus_req_d     = bus_req;
    bus_we_d      = bus_we;
    bus_addr_d    = bus_addr;
    bus_wdata_d   = bus_wdata;
    bus_be_d      = bus_be;

    case (state_q)
      IDLE: begin
        // Read has priority; a concurrent write grant stays pending on the requester side.
        if (ren) begin
          line_d   = rd_addr[ADDR_W-1:OFF_W];
          da_en_d  = 1'b1;
          da_idx_d = rd_addr[OFF_W +: IDX_W];
          phase_d  = 1'b0;
          state_d  = RLOOK;
        end else if (wen) begin
          line_d  = wr_addr[ADDR_W-1:OFF_W];
          wdata_d = wr_data;
          be_d    = wr_be;
          state_d = WLOOK;
        end
      end

      RLOOK: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (hit) begin
          rd_data_d = da_rdata;
          ld_ro_d   = 1'b1;
          state_d   = RRESP;
        end else begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = {line_q, {OFF_W{1'b0}}};
          state_d    = FILL;
        end
      end

      FILL: begin
        if (bus_ack) begin
          bus_req_d  = 1'b0;
          rd_data_d  = bus_rdata;
          da_en_d    = 1'b1;
          da_we_d    = 1'b1;
          da_idx_d   = idx_q;
          da_wdata_d = bus_rdata;
          da_be_d    = '1;
          fill_we    = 1'b1;
          ld_ro_d    = 1'b1;
          state_d    = RRESP;
        end
      end

      WLOOK: begin
        // Write-through: the bus write always happens; the array is only touched on a hit.
        if (hit) begin
          da_en_d    = 1'b1;
          da_we_d    = 1'b1;
          da_idx_d   = idx_q;
          da_wdata_d = wdata_q;
          da_be_d    = be_q;
        end
        bus_req_d   = 1'b1;
        bus_we_d    = 1'b1;
        bus_addr_d  = {line_q, {OFF_W{1'b0}}};
        bus_wdata_d = wdata_q;
        bus_be_d    = be_q;
        state_d     = WBUS;
      end

      WBUS: begin
        if (bus_ack) begin
          bus_req_d     = 1'b0;
          mem_wr_done_d = 1'b1;
          state_d       = WRESP;
        end
      end

      // The requester still holds its grant during the done cycle, so grants are not looked at here.
      RRESP:   state_d = IDLE;
      WRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      line_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      valid_q     <= '0;
      ld_ro       <= 1'b0;
      mem_wr_done <= 1'b0;
      rd_data     <= '0;
      da_en       <= 1'b0;
      da_we       <= 1'b0;
      da_idx      <= '0;
      da_wdata    <= '0;
      da_be       <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      line_q      <= line_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      if (fill_we) valid_q[idx_q] <= 1'b1;
      ld_ro       <= ld_ro_d;
      mem_wr_done <= mem_wr_done_d;
      rd_data     <= rd_data_d;
      da_en       <= da_en_d;
      da_we       <= da_we_d;
      da_idx      <= da_idx_d;
      da_wdata    <= da_wdata_d;
      da_be       <= da_be_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      bus_be      <= bus_be_d;
    end
  end

  // Tags are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_we) tag_arr[idx_q] <= tag_q;
  end

endmodule

// File: tb/tb_dc_access_ctrl.sv
// tb/tb_dc_access_ctrl.sv - scoreboard bench for dc_access_ctrl with SRAM and bus models

module tb_dc_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren, wen;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        ld_ro, mem_wr_done;
  logic [63:0] rd_data;
  logic        da_en, da_we;
  logic [4:0]  da_idx;
  logic [63:0] da_wdata;
  logic [7:0]  da_be;
  logic [63:0] da_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [63:0] bus_rdata = '0;

  dc_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .ld_ro(ld_ro), .rd_data(rd_data), .mem_wr_done(mem_wr_done),
    .da_en(da_en), .da_we(da_we), .da_idx(da_idx), .da_wdata(da_wdata),
    .da_be(da_be), .da_rdata(da_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- memory contents and reference model ----------------
  function automatic logic [63:0] init_line(input int line);
    logic [31:0] l;
    l = line;
    return {l ^ 32'hC0DE_0000, ~l};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic [63:0] ref_mem [int];
  logic [63:0] bus_mem [int];
  int          cache_line [32];

  function automatic logic [63:0] ref_get(input int line);
    return ref_mem.exists(line) ? ref_mem[line] : init_line(line);
  endfunction

  function automatic logic [63:0] bus_get(input int line);
    return bus_mem.exists(line) ? bus_mem[line] : init_line(line);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) cache_line[i] = -1;
  endfunction

  typedef struct {
    bit          wr;
    bit          hit;
    int          issue;
    logic [63:0] data;
    int          bus_n;
    logic [31:0] bus_addr;
    int          da_n;
    logic [4:0]  da_idx;
    logic [7:0]  da_be;
  } exp_t;

  exp_t sb[$];

  // Called in the cycle the grant is presented; the capture edge ends this cycle.
  task automatic push_exp(input bit wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] b);
    exp_t e;
    int   line, idx;
    line       = int'(a >> 3);
    idx        = line % 32;
    e.wr       = wr;
    e.issue    = cyc + 1;
    e.hit      = (cache_line[idx] == line);
    e.bus_addr = a & 32'hFFFF_FFF8;
    e.da_idx   = idx[4:0];
    e.data     = '0;
    if (!wr) begin
      e.data  = ref_get(line);
      e.bus_n = e.hit ? 0 : 1;
      e.da_n  = e.hit ? 0 : 1;
      e.da_be = 8'hFF;
      if (!e.hit) cache_line[idx] = line;
    end else begin
      ref_mem[line] = merge(ref_get(line), d, b);
      e.bus_n = 1;
      e.da_n  = e.hit ? 1 : 0;
      e.da_be = b;
    end
    sb.push_back(e);
  endtask

  // ---------------- data array SRAM model ----------------
  logic [63:0] sram [32];
  always @(posedge clk) begin
    if (da_en) begin
      if (da_we) begin
        for (int b = 0; b < 8; b++) if (da_be[b]) sram[da_idx][8*b +: 8] <= da_wdata[8*b +: 8];
      end else begin
        da_rdata <= sram[da_idx];
      end
    end
  end

  // ---------------- bus responder ----------------
  bit          slow_ack = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  int          bus_total = 0;
  int          ack_cyc = 0;
  logic [31:0] last_bus_addr = '0;
  logic        last_bus_we = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend    = 1'b0;
      bus_ack = 1'b0;
    end else if (bus_ack) begin
      bus_ack = 1'b0;
    end else if (bus_req) begin
      if (!pend) begin
        pend = 1'b1;
        dly  = slow_ack ? 10 : int'($urandom_range(0, 3));
      end
      if (dly == 0) begin
        pend          = 1'b0;
        bus_ack       = 1'b1;
        bus_total++;
        ack_cyc       = cyc;
        last_bus_addr = bus_addr;
        last_bus_we   = bus_we;
        if (bus_we) bus_mem[int'(bus_addr >> 3)] = merge(bus_get(int'(bus_addr >> 3)), bus_wdata, bus_be);
        else        bus_rdata = bus_get(int'(bus_addr >> 3));
      end else begin
        dly--;
      end
    end
  end

  // ---------------- monitor ----------------
  int         done_cnt = 0;
  int         bus_seen = 0;
  int         da_cnt = 0;
  logic [4:0] last_da_idx = '0;
  logic [7:0] last_da_be = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bus_seen = bus_total;
      da_cnt   = 0;
    end else begin
      if (da_en && da_we) begin
        da_cnt++;
        last_da_idx = da_idx;
        last_da_be  = da_be;
      end
      if (ld_ro || mem_wr_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", {62'd0, ld_ro, mem_wr_done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", {62'd0, ld_ro, mem_wr_done}, e.wr ? 64'd1 : 64'd2);
          if (!e.wr) chk("rd_data", rd_data, e.data);
          chk("bus_ops", bus_total - bus_seen, e.bus_n);
          if (e.bus_n > 0) begin
            chk("bus_addr", last_bus_addr, e.bus_addr);
            chk("bus_we", last_bus_we, e.wr);
          end
          chk("da_writes", da_cnt, e.da_n);
          if (e.da_n > 0) begin
            chk("da_idx", last_da_idx, e.da_idx);
            chk("da_be", last_da_be, e.da_be);
          end
          if (!e.wr && e.hit) chk("hit_latency", cyc - e.issue, 2);
          else                chk("ack_to_done", cyc - ack_cyc, 1);
        end
        bus_seen = bus_total;
        da_cnt   = 0;
      end
    end
  end

  // ---------------- driver ----------------
  int exp_done = 0;

  task automatic recover();
    sb.delete();
    rst_n = 1'b0;
    ren   = 1'b0;
    wen   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    model_reset();
    exp_done = done_cnt;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < exp_done && t < 300) begin
      step();
      t++;
    end
    if (done_cnt < exp_done) begin
      chk("done_timeout", done_cnt, exp_done);
      recover();
    end
  endtask

  task automatic do_op(input bit wr, input logic [31:0] a, input logic [63:0] d, input logic [7:0] b);
    if (wr) begin
      wen = 1'b1; wr_addr = a; wr_data = d; wr_be = b;
    end else begin
      ren = 1'b1; rd_addr = a;
    end
    push_exp(wr, a, d, b);
    exp_done++;
    wait_done();
    step();
    ren = 1'b0;
    wen = 1'b0;
  endtask

  task automatic do_dual(input logic [31:0] ra, input logic [31:0] wa, input logic [63:0] d, input logic [7:0] b);
    ren = 1'b1; rd_addr = ra;
    wen = 1'b1; wr_addr = wa; wr_data = d; wr_be = b;
    push_exp(1'b0, ra, '0, '0);
    push_exp(1'b1, wa, d, b);
    exp_done++;
    wait_done();
    step();
    ren = 1'b0;
    exp_done++;
    wait_done();
    step();
    wen = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] t, i, o;
    t = $urandom_range(0, 2);
    i = $urandom_range(0, 7);
    o = $urandom_range(0, 7);
    return (t << 8) | (i << 3) | o;
  endfunction

  initial begin
    int t;
    rst_n = 1'b0; ren = 1'b0; wen = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    model_reset();
    ref_mem[8] = 64'hA5A5_0000_1111_2222;
    bus_mem[8] = 64'hA5A5_0000_1111_2222;
    repeat (3) step();
    chk("rst_ld_ro", ld_ro, 0);
    chk("rst_mem_wr_done", mem_wr_done, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_da_en", da_en, 0);
    chk("rst_da_we", da_we, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    do_op(1'b0, 32'h40, '0, '0);
    do_op(1'b0, 32'h44, '0, '0);
    do_op(1'b1, 32'h40, 64'h0000_0000_FFFF_FFFF, 8'h0F);
    do_op(1'b0, 32'h40, '0, '0);
    do_op(1'b1, 32'h1000, {$urandom, $urandom}, 8'hFF);
    do_op(1'b0, 32'h1000, '0, '0);
    do_dual(32'h40, 32'h48, {$urandom, $urandom}, 8'hF0);

    // Reset while a fill is outstanding: request must drop at once and the line must not be cached.
    slow_ack = 1'b1;
    ren = 1'b1; rd_addr = 32'h140;
    t = 0;
    while (!bus_req && t < 20) begin step(); t++; end
    chk("t6_bus_req_seen", bus_req, 1);
    repeat (3) step();
    rst_n = 1'b0;
    ren   = 1'b0;
    #1;
    chk("t6_bus_req_drop", bus_req, 0);
    chk("t6_da_en_drop", da_en, 0);
    chk("t6_ld_ro_low", ld_ro, 0);
    repeat (2) step();
    rst_n = 1'b1;
    slow_ack = 1'b0;
    model_reset();
    exp_done = done_cnt;
    do_op(1'b0, 32'h40, '0, '0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 15)
        do_dual(rand_addr(), rand_addr(), {$urandom, $urandom}, 8'($urandom_range(1, 255)));
      else if ($urandom_range(0, 1) == 0)
        do_op(1'b1, rand_addr(), {$urandom, $urandom}, 8'($urandom_range(1, 255)));
      else
        do_op(1'b0, rand_addr(), '0, '0);
      if ($urandom_range(0, 3) == 0) step();
    end

    repeat (4) step();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
